// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int unsigned DIGIT_W = 4;

    localparam int unsigned DEF_LIM0 = 10;
    localparam int unsigned DEF_LIM1 = 6;
    localparam int unsigned DEF_LIM2 = 10;
    localparam int unsigned DEF_LIM3 = 6;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button pulses in, display/status out, between debouncer and 7-seg driver.
interface stopwatch_ctrl_if;
    import stopwatch_ctrl_pkg::*;

    logic                   start_stop;
    logic                   clear;
    logic                   split;
    logic [4*DIGIT_W-1:0]   disp_digits;
    logic                   running;
    logic                   frozen;
    logic                   tick;
    logic                   wrap;

    modport master (
        output start_stop, clear, split,
        input  disp_digits, running, frozen, tick, wrap
    );

    modport slave (
        input  start_stop, clear, split,
        output disp_digits, running, frozen, tick, wrap
    );

endinterface

// File: rtl/stopwatch_ctrl_digit.sv
// One limited-increment digit stage: counts 0..L-1, carries out on rollover.
module stopwatch_digit
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned L = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ci,
    output logic [DIGIT_W-1:0] q,
    output logic               co
);

    localparam logic [DIGIT_W:0] LIM_V = (DIGIT_W+1)'(L);

    logic [DIGIT_W:0] inc;
    logic             at_lim;

    // Out-of-range values also satisfy the compare, so they roll to 0 with carry.
    assign inc    = {1'b0, q} + 1'b1;
    assign at_lim = (inc >= LIM_V);
    assign co     = ci & at_lim;

    // Digit register: hold without carry-in, otherwise increment or roll over.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (ci) begin
            q <= at_lim ? '0 : inc[DIGIT_W-1:0];
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: tick prescaler, run/pause/clear FSM, split freeze.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned LIM0     = DEF_LIM0,
    parameter int unsigned LIM1     = DEF_LIM1,
    parameter int unsigned LIM2     = DEF_LIM2,
    parameter int unsigned LIM3     = DEF_LIM3
) (
    input  logic            clk,
    input  logic            reset,
    stopwatch_ctrl_if.slave bus
);

    localparam int unsigned    PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);

    state_t                 state;
    state_t                 next_state;
    logic                   clr_go;
    logic [PW-1:0]          presc;
    logic                   tick;
    logic                   freeze;
    logic [4*DIGIT_W-1:0]   snapshot;
    logic [4*DIGIT_W-1:0]   digits;
    logic [4:0]             carry;
    logic                   digit_rst;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; clear beats start_stop while paused.
    always_comb begin
        next_state = state;
        clr_go     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start_stop) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (bus.start_stop) next_state = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (bus.clear) begin
                    next_state = ST_IDLE;
                    clr_go     = 1'b1;
                end else if (bus.start_stop) begin
                    next_state = ST_RUN;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign tick = (state == ST_RUN) && (presc == PRE_MAX);

    // Prescaler advances only while running; pausing keeps the partial count.
    always_ff @(posedge clk) begin
        if (reset || clr_go) begin
            presc <= '0;
        end else if (state == ST_RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // Split toggles freeze outside IDLE; the snapshot is taken on the 0->1 edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            freeze   <= 1'b0;
            snapshot <= '0;
        end else if (clr_go) begin
            freeze   <= 1'b0;
        end else if (bus.split && (state != ST_IDLE)) begin
            freeze <= ~freeze;
            if (!freeze) snapshot <= digits;
        end
    end

    // Clearing from PAUSED reuses the digit stages' synchronous reset.
    assign digit_rst = reset | clr_go;
    assign carry[0]  = tick;

    stopwatch_digit #(.L(LIM0)) u_d0 (
        .clk(clk), .reset(digit_rst), .ci(carry[0]),
        .q(digits[0*DIGIT_W +: DIGIT_W]), .co(carry[1])
    );
    stopwatch_digit #(.L(LIM1)) u_d1 (
        .clk(clk), .reset(digit_rst), .ci(carry[1]),
        .q(digits[1*DIGIT_W +: DIGIT_W]), .co(carry[2])
    );
    stopwatch_digit #(.L(LIM2)) u_d2 (
        .clk(clk), .reset(digit_rst), .ci(carry[2]),
        .q(digits[2*DIGIT_W +: DIGIT_W]), .co(carry[3])
    );
    stopwatch_digit #(.L(LIM3)) u_d3 (
        .clk(clk), .reset(digit_rst), .ci(carry[3]),
        .q(digits[3*DIGIT_W +: DIGIT_W]), .co(carry[4])
    );

    assign bus.disp_digits = freeze ? snapshot : digits;
    assign bus.running     = (state == ST_RUN);
    assign bus.frozen      = freeze;
    assign bus.tick        = tick;
    assign bus.wrap        = carry[4];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 4-cycle tick.
module tb_stopwatch_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    stopwatch_ctrl_if sw ();

    stopwatch_ctrl #(
        .TICK_DIV(4),
        .LIM0(10),
        .LIM1(6),
        .LIM2(10),
        .LIM3(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(sw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        sw.start_stop = 1'b1; step(1); sw.start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        sw.clear = 1'b1; step(1); sw.clear = 1'b0;
    endtask

    task automatic pulse_split();
        sw.split = 1'b1; step(1); sw.split = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; step(1); reset = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        sw.split      = 1'b0;
        #2;

        // Reset state
        do_reset();
        check("rst_disp", sw.disp_digits, 16'h0000);
        check("rst_flags", {12'd0, sw.running, sw.frozen, sw.tick, sw.wrap}, 16'h0000);

        // IDLE ignores split and clear
        pulse_split();
        pulse_clear();
        check("idle_ign", {14'd0, sw.running, sw.frozen}, 16'h0000);

        // First tick
        pulse_start();
        check("run1", {15'd0, sw.running}, 16'h0001);
        step(2);
        check("no_tick_yet", {15'd0, sw.tick}, 16'h0000);
        step(1);
        check("tick4", {15'd0, sw.tick}, 16'h0001);
        check("tick4_disp", sw.disp_digits, 16'h0000);
        step(1);
        check("first", sw.disp_digits, 16'h0001);
        check("tick_low", {15'd0, sw.tick}, 16'h0000);

        // Carry chain
        step(9 * 4);
        check("t10", sw.disp_digits, 16'h0010);
        step(50 * 4);
        check("t60", sw.disp_digits, 16'h0100);
        step(540 * 4);
        check("t600", sw.disp_digits, 16'h1000);

        // Wrap at 59:59
        step(2999 * 4);
        check("t3599", sw.disp_digits, 16'h5959);
        step(2);
        check("pre_wrap", {15'd0, sw.wrap}, 16'h0000);
        step(1);
        check("wrap_hi", {14'd0, sw.tick, sw.wrap}, 16'h0003);
        step(1);
        check("wrapped", sw.disp_digits, 16'h0000);
        check("wrap_lo", {15'd0, sw.wrap}, 16'h0000);
        check("wrap_run", {15'd0, sw.running}, 16'h0001);

        // Pause with 2 prescaler cycles elapsed
        step(1);
        pulse_start();
        check("paused", {15'd0, sw.running}, 16'h0000);
        step(50);
        check("pause_hold", sw.disp_digits, 16'h0000);
        check("pause_tick", {15'd0, sw.tick}, 16'h0000);
        pulse_start();
        check("resume", {14'd0, sw.running, sw.tick}, 16'h0002);
        step(1);
        check("resume_tick", {15'd0, sw.tick}, 16'h0001);
        step(1);
        check("resume_cnt", sw.disp_digits, 16'h0001);

        // Split freeze
        step(4 * 4);
        check("at5", sw.disp_digits, 16'h0005);
        pulse_split();
        check("frz_on", {15'd0, sw.frozen}, 16'h0001);
        check("frz_disp", sw.disp_digits, 16'h0005);
        step(11);
        check("frz_hold", sw.disp_digits, 16'h0005);
        pulse_split();
        check("frz_off", {15'd0, sw.frozen}, 16'h0000);
        check("unfrz_disp", sw.disp_digits, 16'h0008);
        pulse_start();
        pulse_split();
        check("frz_pause", {14'd0, sw.running, sw.frozen}, 16'h0001);
        pulse_clear();
        check("clr_disp", sw.disp_digits, 16'h0000);
        check("clr_flags", {14'd0, sw.running, sw.frozen}, 16'h0000);

        // clear beats start_stop in PAUSED
        pulse_start();
        step(3 * 4);
        check("at3", sw.disp_digits, 16'h0003);
        pulse_start();
        sw.clear = 1'b1; sw.start_stop = 1'b1;
        step(1);
        sw.clear = 1'b0; sw.start_stop = 1'b0;
        check("clr_pri", sw.disp_digits, 16'h0000);
        check("clr_pri_run", {15'd0, sw.running}, 16'h0000);
        step(5);
        check("idle_stay", {15'd0, sw.running}, 16'h0000);

        // Reset mid-run
        pulse_start();
        step(42 * 4);
        check("at42", sw.disp_digits, 16'h0042);
        step(2);
        do_reset();
        check("rst_run_disp", sw.disp_digits, 16'h0000);
        check("rst_run_flags", {12'd0, sw.running, sw.frozen, sw.tick, sw.wrap}, 16'h0000);
        pulse_start();
        step(2);
        check("rst_presc", {15'd0, sw.tick}, 16'h0000);
        step(1);
        check("rst_presc_tick", {15'd0, sw.tick}, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Controller that sequences a 4-digit MM:SS chain of limited incrementors (digit limits 10/6/10/6) for the BASYS3 lab stopwatch. It contains the tick prescaler, the run/pause/clear state machine and the split (display-freeze) register. It sits between the debounced button pulses and the 7-segment display driver.

Parameters:
TICK_DIV, 100000000, clock cycles per count tick (1 Hz at 100 MHz); must be >= 2
LIM0, 10, limit of seconds-ones digit
LIM1, 6, limit of seconds-tens digit
LIM2, 10, limit of minutes-ones digit
LIM3, 6, limit of minutes-tens digit

Ports:
clk  in  1  system clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
start_stop  in  1  one-cycle pulse from an external debouncer; toggles run/pause
clear  in  1  one-cycle pulse; zeroes the count when paused
split  in  1  one-cycle pulse; toggles display freeze
disp_digits  out  16  displayed value {d3,d2,d1,d0}, 4 bits per digit, BCD-like
running  out  1  high in RUNNING
frozen  out  1  high while the display is frozen
tick  out  1  one-cycle pulse on each count increment
wrap  out  1  one-cycle pulse when 59:59 rolls over to 00:00

Behaviour:
- Reset is synchronous and active-high: reset=1 at a clk edge forces state=IDLE, digits=0, prescaler=0, freeze=0 and the snapshot to 0. All outputs are 0 the following cycle. Reset mid-run has the same effect.
- States are IDLE, RUNNING and PAUSED, held in a 2-bit registered state.
- IDLE:
  - start_stop moves to RUNNING.
  - clear and split are ignored.
- RUNNING:
  - Prescaler counts 0..TICK_DIV-1.
  - On the cycle the prescaler equals TICK_DIV-1, tick=1 combinationally, the prescaler wraps to 0 and the digit chain increments at the same edge.
  - start_stop moves to PAUSED. clear is ignored.
- PAUSED:
  - Prescaler and digits hold. The prescaler is not reset, so the next tick arrives after the remaining cycles.
  - start_stop moves to RUNNING.
  - clear moves to IDLE with digits=0, prescaler=0 and freeze=0.
- Simultaneous events:
  - In PAUSED, clear has priority over start_stop.
  - In RUNNING, a tick coinciding with start_stop is counted, then the state becomes PAUSED.
- Digit chain increment:
  - d0 has ci=tick. Each later stage has ci = co of the previous stage.
  - Per stage: if ci=0, hold. If ci=1 and d+1 >= LIMk, then d becomes 0 and co=1. Otherwise d becomes d+1 and co=0.
  - Out-of-range values (d >= LIMk) saturate: the next increment gives 0 with carry.
- wrap equals co of stage 3, so it pulses exactly at 59:59 -> 00:00 and counting continues.
- Split:
  - In RUNNING or PAUSED, split toggles freeze.
  - When freeze goes 0->1, the snapshot latches the current digits at that edge.
  - Entering IDLE clears freeze.
- Outputs:
  - disp_digits = freeze ? snapshot : digits, registered with no extra latency beyond the digit registers.
  - Digits keep counting while frozen.
- The prescaler width is $clog2(TICK_DIV) bits. Compare against TICK_DIV-1; no overflow is permitted.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2
  - DIGIT_W=4
  - default limits 10/6/10/6
- Sub-module stopwatch_digit #(L): a 4-bit register plus limited increment, with ports clk, reset, ci, q, co. It is instantiated four times and chained.
- The FSM, prescaler and split logic stay in the top.

Test Plan:
1. TICK_DIV=4, reset, then start_stop pulse at cycle 0 -> running=1 at cycle 1; first tick at the 4th RUNNING cycle; disp_digits=16'h0001 on the next edge.
2. Run 10 ticks -> 16'h0010. Run 60 ticks -> 16'h0100. Run 600 ticks -> 16'h1000. Each carry takes effect on the same edge as its tick.
3. Run 3600 ticks -> 16'h0000; wrap=1 for exactly one cycle, coincident with that tick; running stays 1.
4. Pause with 2 prescaler cycles elapsed, wait 50 cycles, resume -> next tick after exactly 2 more RUNNING cycles; digits unchanged during the pause.
5. split at 16'h0005, run 3 ticks -> disp stays 0005 with frozen=1. split again -> disp=0008. split then clear while paused -> IDLE, disp=0000, frozen=0.
6. In PAUSED, clear and start_stop in the same cycle -> IDLE with digits 0. reset during RUNNING at 16'h0042 -> all outputs 0 on the next cycle.
